// File: rtl/arb_pkg.sv
// Shared constants, FSM state type and one-hot helper for the
// 8-requester round-robin arbiter.
package arb_pkg;

  localparam int N       = 8;
  localparam int IDXW    = 3;
  // Maximum grant hold in cycles; only consulted when ARB_TIMEOUT_EN is defined.
  localparam int TIMEOUT = 16;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_e;

  function automatic logic [N-1:0] onehot_of(input logic [IDXW-1:0] idx);
    onehot_of      = '0;
    onehot_of[idx] = 1'b1;
  endfunction

endpackage

// File: rtl/rr_arbiter_8_if.sv
// Request/grant bus between the requesters and the arbiter.
// slave = arbiter side, master = requester/testbench side.
interface rr_arbiter_8_if;
  import arb_pkg::*;

  logic [N-1:0] req;
  logic         done;
  logic [N-1:0] gnt;
  logic         gnt_valid;
  logic         timeout;

  modport slave  (input  req, done, output gnt, gnt_valid, timeout);
  modport master (output req, done, input  gnt, gnt_valid, timeout);

endinterface

// File: rtl/rr_arbiter_8_pick.sv
// Combinational round-robin picker: first set bit of (req & ~excl)
// scanning from ptr upward with wrap-around.
module rr_pick
  import arb_pkg::*;
(
  input  logic [N-1:0]    i_req,
  input  logic [IDXW-1:0] i_ptr,
  input  logic [N-1:0]    i_excl,
  output logic [IDXW-1:0] o_idx,
  output logic [N-1:0]    o_onehot,
  output logic            o_any
);

  logic [N-1:0] w_masked;

  assign w_masked = i_req & ~i_excl;

  // Rotating priority scan; IDXW-bit addition wraps modulo N for free.
  always_comb begin
    logic [IDXW-1:0] v_cand;
    o_idx  = '0;
    o_any  = 1'b0;
    v_cand = '0;
    for (int i = 0; i < N; i++) begin
      v_cand = i_ptr + IDXW'(i);
      if (!o_any && w_masked[v_cand]) begin
        o_idx = v_cand;
        o_any = 1'b1;
      end
    end
  end

  assign o_onehot = o_any ? onehot_of(o_idx) : '0;

endmodule

// File: rtl/rr_arbiter_8.sv
// Round-robin arbiter, 8 requesters, registered strictly one-hot grant.
// Grant is held until done (or the owner drops its request), then
// priority rotates to owner+1 with a same-edge handover when possible.
// Optional hold timeout: define ARB_TIMEOUT_EN.
module rr_arbiter_8
  import arb_pkg::*;
(
  input  logic           clk,
  input  logic           rst_n,
  rr_arbiter_8_if.slave  bus
);

  arb_state_e      r_state;
  logic [IDXW-1:0] r_ptr;
  logic [IDXW-1:0] r_owner;
  logic [N-1:0]    r_gnt;
  logic            r_gnt_valid;

  logic [IDXW-1:0] w_pick_ptr;
  logic [N-1:0]    w_excl;
  logic [IDXW-1:0] w_win_idx;
  logic [N-1:0]    w_win_oh;
  logic            w_win_any;
  logic            w_owner_req;
  logic            w_to_fire;
  logic            w_release;

  // While granting, the next winner is searched from owner+1 with the
  // owner masked out, so a release can hand over on the same edge and
  // the releasing requester cannot immediately re-win.
  assign w_pick_ptr  = (r_state == GRANT) ? r_owner + IDXW'(1) : r_ptr;
  assign w_excl      = (r_state == GRANT) ? onehot_of(r_owner) : '0;
  assign w_owner_req = bus.req[r_owner];

  rr_pick u_pick (
    .i_req    (bus.req),
    .i_ptr    (w_pick_ptr),
    .i_excl   (w_excl),
    .o_idx    (w_win_idx),
    .o_onehot (w_win_oh),
    .o_any    (w_win_any)
  );

`ifdef ARB_TIMEOUT_EN
  localparam int CNTW = $clog2(TIMEOUT) + 1;

  logic [CNTW-1:0] r_cnt;
  logic            r_timeout;

  // Force-release only fires when the grant would otherwise be held.
  assign w_to_fire = (r_state == GRANT) && !bus.done && w_owner_req &&
                     (r_cnt == CNTW'(TIMEOUT - 1));

  // Hold counter: zero outside a held grant, counts cycles held without done.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt     <= '0;
      r_timeout <= 1'b0;
    end else begin
      r_timeout <= w_to_fire;
      if (r_state != GRANT || w_release)
        r_cnt <= '0;
      else
        r_cnt <= r_cnt + CNTW'(1);
    end
  end

  assign bus.timeout = r_timeout;
`else
  assign w_to_fire   = 1'b0;
  assign bus.timeout = 1'b0;
`endif

  // done wins over a simultaneous request drop; both release identically.
  assign w_release = (r_state == GRANT) && (bus.done || !w_owner_req || w_to_fire);

  // Arbitration FSM with registered grant outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_ptr       <= '0;
      r_owner     <= '0;
      r_gnt       <= '0;
      r_gnt_valid <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_win_any) begin
            r_owner     <= w_win_idx;
            r_gnt       <= w_win_oh;
            r_gnt_valid <= 1'b1;
            r_state     <= GRANT;
          end
        end
        GRANT: begin
          if (w_release) begin
            r_ptr <= r_owner + IDXW'(1);
            if (w_win_any) begin
              r_owner     <= w_win_idx;
              r_gnt       <= w_win_oh;
              r_gnt_valid <= 1'b1;
            end else begin
              r_gnt       <= '0;
              r_gnt_valid <= 1'b0;
              r_state     <= IDLE;
            end
          end
        end
        default: begin
          r_state     <= IDLE;
          r_gnt       <= '0;
          r_gnt_valid <= 1'b0;
        end
      endcase
    end
  end

  assign bus.gnt       = r_gnt;
  assign bus.gnt_valid = r_gnt_valid;

endmodule
